// File: rtl/exe_stage.sv
// Execute stage: ID/EXE pipeline register, operand forwarding, ALU, branch-target
// adder and a bit-serial shift-add multiplier that stalls the front end while busy.
module exe_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_wreg,
  input  logic        id_m2reg,
  input  logic        id_wmem,
  input  logic        id_branch,
  input  logic [3:0]  id_aluc,
  input  logic        id_aluimm,
  input  logic        id_shift,
  input  logic [4:0]  id_sa,
  input  logic [31:0] id_qa,
  input  logic [31:0] id_qb,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_destR,
  input  logic [1:0]  id_fwdA,
  input  logic [1:0]  id_fwdB,
  input  logic [31:0] fwd_mem,
  input  logic [31:0] fwd_wb,
  input  logic        flush,
  input  logic [3:0]  ID_ins_type,
  input  logic [3:0]  ID_ins_number,
  output logic        ex_stall,
  output logic        ex_wreg,
  output logic        ex_m2reg,
  output logic        ex_wmem,
  output logic        ex_branch,
  output logic [31:0] ex_aluR,
  output logic [31:0] ex_inB,
  output logic [4:0]  ex_destR,
  output logic [31:0] ex_pc,
  output logic        ex_zero,
  output logic [3:0]  EXE_ins_type,
  output logic [3:0]  EXE_ins_number
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic        branch;
    logic [3:0]  aluc;
    logic        aluimm;
    logic        shift;
    logic [4:0]  sa;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  destR;
    logic [1:0]  fwdA;
    logic [1:0]  fwdB;
    logic [3:0]  ins_type;
    logic [3:0]  ins_number;
  } idex_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mul_state_e;

  idex_t          idex_q, idex_d;
  mul_state_e     state_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    mul_a_q, mul_b_q, prod_q;
  logic [31:0]    fwd_a_s, fwd_b_s, op_a_s, op_b_s, alu_s;
  logic           is_mul_s;

  function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] reg_v,
                                          input logic [31:0] mem_v, input logic [31:0] wb_v);
    case (sel)
      2'b01:   fwd_sel = mem_v;
      2'b10:   fwd_sel = wb_v;
      default: fwd_sel = reg_v;
    endcase
  endfunction

  assign fwd_a_s  = fwd_sel(idex_q.fwdA, idex_q.qa, fwd_mem, fwd_wb);
  assign fwd_b_s  = fwd_sel(idex_q.fwdB, idex_q.qb, fwd_mem, fwd_wb);
  assign op_a_s   = idex_q.shift  ? {27'd0, idex_q.sa} : fwd_a_s;
  assign op_b_s   = idex_q.aluimm ? idex_q.imm : fwd_b_s;
  assign is_mul_s = (idex_q.aluc == OP_MUL);

  // Stall covers the first EX cycle of a MUL plus every iteration cycle
  assign ex_stall = ((state_q == S_IDLE) && is_mul_s && !flush) || (state_q == S_BUSY);

  // ALU result select
  always_comb begin
    alu_s = op_a_s + op_b_s;
    case (idex_q.aluc)
      4'b0000: alu_s = op_a_s + op_b_s;
      4'b0001: alu_s = op_a_s - op_b_s;
      4'b0010: alu_s = op_a_s & op_b_s;
      4'b0011: alu_s = op_a_s | op_b_s;
      4'b0100: alu_s = op_a_s ^ op_b_s;
      4'b0101: alu_s = op_b_s << op_a_s[4:0];
      4'b0110: alu_s = op_b_s >> op_a_s[4:0];
      4'b0111: alu_s = $unsigned($signed(op_b_s) >>> op_a_s[4:0]);
      4'b1001: alu_s = {op_b_s[15:0], 16'd0};
      4'b1000: alu_s = prod_q;
      default: alu_s = op_a_s + op_b_s;
    endcase
  end

  // ID/EXE next state: flush beats stall beats load
  always_comb begin
    idex_d = idex_q;
    if (flush) begin
      idex_d = '0;
    end else if (ex_stall) begin
      idex_d = idex_q;
    end else begin
      idex_d.wreg       = id_wreg;
      idex_d.m2reg      = id_m2reg;
      idex_d.wmem       = id_wmem;
      idex_d.branch     = id_branch;
      idex_d.aluc       = id_aluc;
      idex_d.aluimm     = id_aluimm;
      idex_d.shift      = id_shift;
      idex_d.sa         = id_sa;
      idex_d.qa         = id_qa;
      idex_d.qb         = id_qb;
      idex_d.imm        = id_imm;
      idex_d.pc         = id_pc;
      idex_d.destR      = id_destR;
      idex_d.fwdA       = id_fwdA;
      idex_d.fwdB       = id_fwdB;
      idex_d.ins_type   = ID_ins_type;
      idex_d.ins_number = ID_ins_number;
    end
  end

  // ID/EXE pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  // Multiplier FSM with datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mul_a_q <= 32'd0;
      mul_b_q <= 32'd0;
      prod_q  <= 32'd0;
    end else if (flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_mul_s) begin
            state_q <= S_BUSY;
            mul_a_q <= op_a_s;
            mul_b_q <= op_b_s;
            prod_q  <= 32'd0;
            cnt_q   <= '0;
          end
        end
        S_BUSY: begin
          if (mul_b_q[0]) prod_q <= prod_q + mul_a_q;
          mul_a_q <= {mul_a_q[30:0], 1'b0};
          mul_b_q <= {1'b0, mul_b_q[31:1]};
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // While stalled, MEM sees a bubble so no spurious writes occur
  assign ex_wreg        = idex_q.wreg   & ~ex_stall;
  assign ex_m2reg       = idex_q.m2reg  & ~ex_stall;
  assign ex_wmem        = idex_q.wmem   & ~ex_stall;
  assign ex_branch      = idex_q.branch & ~ex_stall;
  assign EXE_ins_type   = ex_stall ? 4'd0 : idex_q.ins_type;
  assign EXE_ins_number = ex_stall ? 4'd0 : idex_q.ins_number;
  assign ex_aluR        = alu_s;
  assign ex_zero        = (alu_s == 32'd0);
  assign ex_inB         = fwd_b_s;
  assign ex_destR       = idex_q.destR;
  assign ex_pc          = idex_q.pc + {idex_q.imm[29:0], 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_wreg, id_m2reg, id_wmem, id_branch;
  logic [3:0]  id_aluc;
  logic        id_aluimm, id_shift;
  logic [4:0]  id_sa;
  logic [31:0] id_qa, id_qb, id_imm, id_pc;
  logic [4:0]  id_destR;
  logic [1:0]  id_fwdA, id_fwdB;
  logic [31:0] fwd_mem, fwd_wb;
  logic        flush;
  logic [3:0]  ID_ins_type, ID_ins_number;
  logic        ex_stall, ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_zero;
  logic [31:0] ex_aluR, ex_inB, ex_pc;
  logic [4:0]  ex_destR;
  logic [3:0]  EXE_ins_type, EXE_ins_number;

  int n_tests = 0;
  int n_fail  = 0;

  exe_stage #(.MUL_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem), .id_branch(id_branch),
    .id_aluc(id_aluc), .id_aluimm(id_aluimm), .id_shift(id_shift), .id_sa(id_sa),
    .id_qa(id_qa), .id_qb(id_qb), .id_imm(id_imm), .id_pc(id_pc), .id_destR(id_destR),
    .id_fwdA(id_fwdA), .id_fwdB(id_fwdB), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
    .flush(flush), .ID_ins_type(ID_ins_type), .ID_ins_number(ID_ins_number),
    .ex_stall(ex_stall), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_branch(ex_branch), .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_destR(ex_destR),
    .ex_pc(ex_pc), .ex_zero(ex_zero), .EXE_ins_type(EXE_ins_type),
    .EXE_ins_number(EXE_ins_number)
  );

  always #5 clk = ~clk;

  task automatic clear_ins();
    id_wreg = 1'b0; id_m2reg = 1'b0; id_wmem = 1'b0; id_branch = 1'b0;
    id_aluc = 4'd0; id_aluimm = 1'b0; id_shift = 1'b0; id_sa = 5'd0;
    id_qa = 32'd0; id_qb = 32'd0; id_imm = 32'd0; id_pc = 32'd0; id_destR = 5'd0;
    id_fwdA = 2'b00; id_fwdB = 2'b00; ID_ins_type = 4'd0; ID_ins_number = 4'd0;
  endtask

  task automatic set_op(input logic [3:0] aluc, input logic [31:0] qa, input logic [31:0] qb);
    clear_ins();
    id_aluc = aluc; id_qa = qa; id_qb = qb; id_wreg = 1'b1; id_destR = 5'd5;
    ID_ins_type = 4'h3; ID_ins_number = 4'h9;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (ex_stall !== 1'b0 || ex_wreg !== 1'b0 || ex_aluR !== 32'd0 || ex_zero !== 1'b1 ||
        ex_pc !== 32'd0 || EXE_ins_type !== 4'd0) begin
      n_fail++;
      $display("FAIL reset: stall=%b wreg=%b aluR=%h zero=%b pc=%h, required 0 0 0 1 0",
               ex_stall, ex_wreg, ex_aluR, ex_zero, ex_pc);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_add_fwd();
    set_op(4'b0000, 32'h0, 32'h5);
    id_fwdA = 2'b01; fwd_mem = 32'h10; id_destR = 5'd3;
    step();
    clear_ins();
    n_tests++;
    if (ex_aluR !== 32'h15 || ex_wreg !== 1'b1 || ex_stall !== 1'b0 || ex_destR !== 5'd3) begin
      n_fail++;
      $display("FAIL add_fwd: aluR=%h wreg=%b stall=%b destR=%0d, required 15 1 0 3",
               ex_aluR, ex_wreg, ex_stall, ex_destR);
    end
    // fwd_wb on B, store data is forwarded qb even when immediate is used
    set_op(4'b0000, 32'h1, 32'h0);
    id_fwdB = 2'b10; fwd_wb = 32'hABCD_0000; id_aluimm = 1'b1; id_imm = 32'h22;
    step();
    clear_ins();
    n_tests++;
    if (ex_aluR !== 32'h23 || ex_inB !== 32'hABCD_0000) begin
      n_fail++;
      $display("FAIL inB_fwd: aluR=%h inB=%h, required 23 abcd0000", ex_aluR, ex_inB);
    end
    fwd_mem = 32'd0; fwd_wb = 32'd0;
  endtask

  task automatic test_branch();
    set_op(4'b0001, 32'h1234, 32'h1234);
    id_branch = 1'b1; id_pc = 32'h100; id_imm = 32'd3; id_wreg = 1'b0;
    step();
    clear_ins();
    n_tests++;
    if (ex_zero !== 1'b1 || ex_branch !== 1'b1 || ex_pc !== 32'h10C || ex_aluR !== 32'd0) begin
      n_fail++;
      $display("FAIL branch: zero=%b branch=%b pc=%h aluR=%h, required 1 1 10c 0",
               ex_zero, ex_branch, ex_pc, ex_aluR);
    end
  endtask

  task automatic test_alu_ops();
    set_op(4'b0111, 32'h0, 32'h8000_0000);
    id_shift = 1'b1; id_sa = 5'd4; id_qa = 32'hFFFF_FFFF;
    step();
    n_tests++;
    if (ex_aluR !== 32'hF800_0000) begin
      n_fail++;
      $display("FAIL sra: aluR=%h, required f8000000", ex_aluR);
    end
    set_op(4'b0000, 32'hFFFF_FFFF, 32'h1);
    step();
    n_tests++;
    if (ex_aluR !== 32'd0 || ex_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL add_wrap: aluR=%h zero=%b, required 0 1", ex_aluR, ex_zero);
    end
    set_op(4'b1001, 32'h0, 32'h0);
    id_aluimm = 1'b1; id_imm = 32'h0000_1234;
    step();
    n_tests++;
    if (ex_aluR !== 32'h1234_0000 || ex_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL lui: aluR=%h zero=%b, required 12340000 0", ex_aluR, ex_zero);
    end
    set_op(4'b0110, 32'h0, 32'h8000_0000);
    id_shift = 1'b1; id_sa = 5'd4;
    step();
    n_tests++;
    if (ex_aluR !== 32'h0800_0000) begin
      n_fail++;
      $display("FAIL srl: aluR=%h, required 08000000", ex_aluR);
    end
    set_op(4'b1111, 32'd20, 32'd22);
    step();
    clear_ins();
    n_tests++;
    if (ex_aluR !== 32'd42) begin
      n_fail++;
      $display("FAIL undef_add: aluR=%h, required 2a", ex_aluR);
    end
  endtask

  task automatic test_mul();
    logic [31:0] va [2] = '{32'd7, 32'hFFFF_FFFF};
    logic [31:0] vb [2] = '{32'd6, 32'd2};
    logic [31:0] vr [2] = '{32'd42, 32'hFFFF_FFFE};
    for (int k = 0; k < 2; k++) begin
      int  cnt = 0;
      bit  bub_bad = 1'b0;
      set_op(4'b1000, va[k], vb[k]);
      step();
      clear_ins();
      while (ex_stall === 1'b1 && cnt < 100) begin
        if (ex_wreg !== 1'b0 || EXE_ins_type !== 4'd0 || EXE_ins_number !== 4'd0) bub_bad = 1'b1;
        cnt++;
        step();
      end
      n_tests++;
      if (cnt !== 33 || bub_bad) begin
        n_fail++;
        $display("FAIL mul_stall[%0d]: stall cycles=%0d bubble_err=%b, required 33 0", k, cnt, bub_bad);
      end
      n_tests++;
      if (ex_aluR !== vr[k] || ex_wreg !== 1'b1 || EXE_ins_type !== 4'h3 || EXE_ins_number !== 4'h9) begin
        n_fail++;
        $display("FAIL mul_result[%0d]: aluR=%h wreg=%b tags=%h/%h, required %h 1 3/9",
                 k, ex_aluR, ex_wreg, EXE_ins_type, EXE_ins_number, vr[k]);
      end
      step();
      n_tests++;
      if (ex_wreg !== 1'b0 || ex_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_pulse[%0d]: wreg=%b stall=%b, required 0 0", k, ex_wreg, ex_stall);
      end
    end
  endtask

  task automatic test_flush();
    int wr = 0;
    set_op(4'b1000, 32'd9, 32'd9);
    step();
    clear_ins();
    repeat (11) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_tests++;
    if (ex_stall !== 1'b0 || ex_wreg !== 1'b0 || ex_aluR !== 32'd0 || ex_destR !== 5'd0 ||
        ex_pc !== 32'd0 || dut.state_q !== dut.S_IDLE) begin
      n_fail++;
      $display("FAIL flush: stall=%b wreg=%b aluR=%h destR=%0d pc=%h, required all 0 and idle",
               ex_stall, ex_wreg, ex_aluR, ex_destR, ex_pc);
    end
    for (int i = 0; i < 40; i++) begin
      if (ex_wreg !== 1'b0 || ex_stall !== 1'b0) wr++;
      step();
    end
    n_tests++;
    if (wr !== 0) begin
      n_fail++;
      $display("FAIL flush_quiet: %0d cycles with wreg/stall, required 0", wr);
    end
  endtask

  task automatic test_reset_mid_mul();
    set_op(4'b1000, 32'd5, 32'd5);
    step();
    clear_ins();
    repeat (5) step();
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (ex_stall !== 1'b0 || ex_wreg !== 1'b0 || ex_aluR !== 32'd0 || ex_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_mul: stall=%b wreg=%b aluR=%h zero=%b, required 0 0 0 1",
               ex_stall, ex_wreg, ex_aluR, ex_zero);
    end
    #2 rst_n = 1'b1;
    set_op(4'b0000, 32'd100, 32'd23);
    step();
    clear_ins();
    n_tests++;
    if (ex_aluR !== 32'd123 || ex_wreg !== 1'b1 || ex_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL add_after_reset: aluR=%h wreg=%b stall=%b, required 7b 1 0",
               ex_aluR, ex_wreg, ex_stall);
    end
  endtask

  task automatic test_back_to_back();
    int c1 = 0;
    int c2 = 0;
    set_op(4'b1000, 32'd3, 32'd5);
    step();
    set_op(4'b1000, 32'd4, 32'd4);
    while (ex_stall === 1'b1 && c1 < 100) begin c1++; step(); end
    n_tests++;
    if (c1 !== 33 || ex_aluR !== 32'd15 || ex_wreg !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: stall=%0d aluR=%h wreg=%b, required 33 f 1", c1, ex_aluR, ex_wreg);
    end
    step();
    clear_ins();
    while (ex_stall === 1'b1 && c2 < 100) begin c2++; step(); end
    n_tests++;
    if (c2 !== 33 || ex_aluR !== 32'd16 || ex_wreg !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: stall=%0d aluR=%h wreg=%b, required 33 10 1", c2, ex_aluR, ex_wreg);
    end
    step();
  endtask

  initial begin
    clear_ins();
    fwd_mem = 32'd0; fwd_wb = 32'd0; flush = 1'b0;
    test_reset();
    test_add_fwd();
    test_branch();
    test_alu_ops();
    test_mul();
    test_flush();
    test_reset_mid_mul();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
